wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Write-back arbiter sharing the single register-file write port between the ALU, the load unit and the jump-link path. Each source has a one-entry holding slot with a valid/ready handshake. A priority arbiter picks one slot per cycle and drives a registered write to the decode unit's `i_wb_rd_*` port. Writes to x0 are absorbed without reaching the register file.

## Interface
Clock is `clk`. Reset is `rst`, synchronous and active-high. Both are fixed.

Parameters:
- `XLEN`, 32: data width.
- `STARVE_LIMIT`, 4: consecutive losses before a source is forced to win. Range 1–7. Used only with `WB_ARB_STARVE_GUARD_EN`.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  synchronous active-high reset
- `i_alu_wvalid`  in  1  ALU result valid
- `o_alu_wready`  out  1  ALU slot can accept
- `i_alu_waddr`  in  5  ALU destination register
- `i_alu_wdata`  in  XLEN  ALU result
- `i_load_wvalid` / `o_load_wready` / `i_load_waddr` / `i_load_wdata`: same set for the load unit
- `i_jump_wvalid` / `o_jump_wready` / `i_jump_waddr` / `i_jump_wdata`: same set for the jump link (pc+4)
- `o_wb_rd_wvalid`  out  1  register-file write strobe
- `o_wb_rd_waddr`  out  5  write address
- `o_wb_rd_wdata`  out  XLEN  write data
- `o_busy`  out  1  any holding slot occupied

## Operation
- One holding slot per source: valid bit, 5-bit address, XLEN data.
- A source transfer occurs on `i_*_wvalid & o_*_wready`.
- `o_*_wready = ~slot_valid | slot_grant`. A slot can refill in the same cycle it is granted.
- A transfer with `waddr == 0` completes the handshake but is not stored. The slot is unchanged, or becomes empty if it was granted that cycle.
- Arbitration is combinational over occupied slots. Exactly one grant per cycle when `o_busy` is high.
- Fixed priority: load > jump > alu.
- Grant effects at the clock edge:
  - the output registers load the granted slot;
  - `o_wb_rd_wvalid` is asserted;
  - the granted slot clears, unless it is refilled in the same cycle.
- No grant in a cycle: `o_wb_rd_wvalid` = 0. `o_wb_rd_waddr` and `o_wb_rd_wdata` hold their previous values.
- `o_busy` = OR of the three slot valid bits.

## Timing
- Reset values: all slots empty; `o_wb_rd_wvalid` = 0, `o_wb_rd_waddr` = 0, `o_wb_rd_wdata` = 0; all `o_*_wready` = 1; starvation counters = 0.
- Reset asserted mid-operation discards all held results. No write strobe is issued in the cycle after reset.
- Latency:
  - source handshake in cycle N;
  - slot valid in N+1;
  - if granted in N+1, `o_wb_rd_wvalid` is high in N+2.
  - Uncontended latency is 2 cycles.
- `o_wb_rd_wvalid` is a single-cycle pulse per granted write.
- Sustained throughput is 1 write per cycle. A single source streaming back-to-back sees `wready` held high.
- Simultaneous events:
  - all three sources valid in the same cycle: writes emerge on three consecutive cycles in order load, jump, alu;
  - the losing sources' `wready` is low until they are granted.
- Same `waddr` from two sources: both writes are issued in grant order. The later write wins in the register file. No merging.

## Configuration
- Macro: `WB_ARB_STARVE_GUARD_EN`.
- Defined:
  - each slot has a 3-bit loss counter;
  - the counter increments when the slot is valid and not granted, and saturates at `STARVE_LIMIT`;
  - the counter clears on grant or when the slot is empty;
  - any slot whose counter equals `STARVE_LIMIT` overrides the fixed priority;
  - ties between starved slots resolve by the fixed order.
- Undefined: no counters, pure fixed priority. A continuously refilled load slot can starve alu indefinitely.

## Structure
- Shared package `rv32i_pkg` holds:
  - `typedef enum logic [1:0] wb_src_e {WB_SRC_LOAD, WB_SRC_JUMP, WB_SRC_ALU}`;
  - `localparam int NUM_WB_SRC = 3`;
  - `localparam logic [4:0] REG_X0 = 0`.
- Sub-module `wb_hold_slot`: one-entry holding register with refill-on-grant, x0 drop and the optional loss counter. Instantiated three times.
- The top level contains the arbiter and the output registers.

## Test plan
- Single ALU write, addr 5, data 0xDEADBEEF, cycle N → `o_wb_rd_wvalid` pulse in N+2 with addr 5 / 0xDEADBEEF; `o_busy` high in N+1 only.
- Load (addr 1), jump (addr 2) and alu (addr 3) all valid in cycle N → writes to 1, 2, 3 in cycles N+2, N+3, N+4; `o_alu_wready` low in N+1..N+2.
- Load writes to x0, data 0x1234 → handshake completes, no `o_wb_rd_wvalid`, `o_busy` stays low.
- Load streams valid every cycle while ALU holds one write, guard defined, `STARVE_LIMIT` = 4 → ALU write is issued after at most 4 lost arbitrations; guard undefined → ALU never issues while load streams.
- `rst` pulsed while all slots are full → next cycle all `wready` = 1, `o_busy` = 0, and no strobe is ever issued for the discarded data.
- ALU back-to-back with addrs 1..8 and no contention → 8 consecutive strobes, `o_alu_wready` constant 1.

Source files
------------

// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared write-back source encoding, constants and priority helper
package rv32i_pkg;

    typedef enum logic [1:0] {
        WB_SRC_LOAD,
        WB_SRC_JUMP,
        WB_SRC_ALU
    } wb_src_e;

    localparam int NUM_WB_SRC = 3;
    localparam logic [4:0] REG_X0 = 5'd0;

    // One-hot pick of the highest-priority requester: load > jump > alu.
    function automatic logic [NUM_WB_SRC-1:0] wb_fixed_pick(input logic [NUM_WB_SRC-1:0] req);
        logic [NUM_WB_SRC-1:0] pick;
        pick = '0;
        if (req[WB_SRC_LOAD]) begin
            pick[WB_SRC_LOAD] = 1'b1;
        end else if (req[WB_SRC_JUMP]) begin
            pick[WB_SRC_JUMP] = 1'b1;
        end else if (req[WB_SRC_ALU]) begin
            pick[WB_SRC_ALU] = 1'b1;
        end
        return pick;
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// rtl/wb_arbiter_if.sv - valid/ready write handshake from one result source
interface wb_arbiter_if #(
    parameter int XLEN = 32
);
    logic            wvalid;
    logic            wready;
    logic [4:0]      waddr;
    logic [XLEN-1:0] wdata;

    modport master (output wvalid, output waddr, output wdata, input wready);
    modport slave  (input wvalid, input waddr, input wdata, output wready);
endinterface

// File: rtl/wb_hold_slot.sv
// rtl/wb_hold_slot.sv - one-entry result holding slot with refill-on-grant, x0 drop, optional loss counter (WB_ARB_STARVE_GUARD_EN)
module wb_hold_slot
    import rv32i_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    wb_arbiter_if.slave      src_if,
    input  logic             grant_i,
    output logic             valid_o,
    output logic [4:0]       addr_o,
    output logic [XLEN-1:0]  data_o,
    output logic             starved_o
);

    localparam logic [2:0] LIMIT_C = 3'(STARVE_LIMIT);

    logic            valid_q, valid_d;
    logic [4:0]      addr_q, addr_d;
    logic [XLEN-1:0] data_q, data_d;
    logic            take;

    // A granted slot drains this cycle, so it can accept a replacement at once.
    assign src_if.wready = ~valid_q | grant_i;

    // Writes to x0 complete the handshake but are never stored.
    assign take = src_if.wvalid & src_if.wready & (src_if.waddr != REG_X0);

    // Next slot contents: a refill overrides the drain caused by a grant.
    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (grant_i) begin
            valid_d = 1'b0;
        end
        if (take) begin
            valid_d = 1'b1;
            addr_d  = src_if.waddr;
            data_d  = src_if.wdata;
        end
    end

    // Slot storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign addr_o  = addr_q;
    assign data_o  = data_q;

`ifdef WB_ARB_STARVE_GUARD_EN
    logic [2:0] cnt_q, cnt_d;

    // Count lost arbitrations while occupied; saturate at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (!valid_q || grant_i) begin
            cnt_d = 3'd0;
        end else if (cnt_q != LIMIT_C) begin
            cnt_d = cnt_q + 3'd1;
        end
    end

    // Loss counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 3'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign starved_o = valid_q & (cnt_q == LIMIT_C);
`else
    // Without the guard the limit has no consumer.
    logic unused_limit;
    assign unused_limit = ^LIMIT_C;
    assign starved_o    = 1'b0;
`endif

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - write-back arbiter for ALU/load/jump results onto the register-file write port (option: WB_ARB_STARVE_GUARD_EN)
module wb_arbiter
    import rv32i_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_alu_wvalid,
    output logic             o_alu_wready,
    input  logic [4:0]       i_alu_waddr,
    input  logic [XLEN-1:0]  i_alu_wdata,
    input  logic             i_load_wvalid,
    output logic             o_load_wready,
    input  logic [4:0]       i_load_waddr,
    input  logic [XLEN-1:0]  i_load_wdata,
    input  logic             i_jump_wvalid,
    output logic             o_jump_wready,
    input  logic [4:0]       i_jump_waddr,
    input  logic [XLEN-1:0]  i_jump_wdata,
    output logic             o_wb_rd_wvalid,
    output logic [4:0]       o_wb_rd_waddr,
    output logic [XLEN-1:0]  o_wb_rd_wdata,
    output logic             o_busy
);

    wb_arbiter_if #(.XLEN(XLEN)) load_if ();
    wb_arbiter_if #(.XLEN(XLEN)) jump_if ();
    wb_arbiter_if #(.XLEN(XLEN)) alu_if ();

    assign load_if.wvalid = i_load_wvalid;
    assign load_if.waddr  = i_load_waddr;
    assign load_if.wdata  = i_load_wdata;
    assign o_load_wready  = load_if.wready;

    assign jump_if.wvalid = i_jump_wvalid;
    assign jump_if.waddr  = i_jump_waddr;
    assign jump_if.wdata  = i_jump_wdata;
    assign o_jump_wready  = jump_if.wready;

    assign alu_if.wvalid  = i_alu_wvalid;
    assign alu_if.waddr   = i_alu_waddr;
    assign alu_if.wdata   = i_alu_wdata;
    assign o_alu_wready   = alu_if.wready;

    logic [NUM_WB_SRC-1:0] slot_valid;
    logic [NUM_WB_SRC-1:0] slot_starved;
    logic [NUM_WB_SRC-1:0] grant;
    logic [4:0]            slot_addr [NUM_WB_SRC];
    logic [XLEN-1:0]       slot_data [NUM_WB_SRC];

    wb_hold_slot #(.XLEN(XLEN), .STARVE_LIMIT(STARVE_LIMIT)) u_load_slot (
        .clk       (clk),
        .rst       (rst),
        .src_if    (load_if),
        .grant_i   (grant[WB_SRC_LOAD]),
        .valid_o   (slot_valid[WB_SRC_LOAD]),
        .addr_o    (slot_addr[WB_SRC_LOAD]),
        .data_o    (slot_data[WB_SRC_LOAD]),
        .starved_o (slot_starved[WB_SRC_LOAD])
    );

    wb_hold_slot #(.XLEN(XLEN), .STARVE_LIMIT(STARVE_LIMIT)) u_jump_slot (
        .clk       (clk),
        .rst       (rst),
        .src_if    (jump_if),
        .grant_i   (grant[WB_SRC_JUMP]),
        .valid_o   (slot_valid[WB_SRC_JUMP]),
        .addr_o    (slot_addr[WB_SRC_JUMP]),
        .data_o    (slot_data[WB_SRC_JUMP]),
        .starved_o (slot_starved[WB_SRC_JUMP])
    );

    wb_hold_slot #(.XLEN(XLEN), .STARVE_LIMIT(STARVE_LIMIT)) u_alu_slot (
        .clk       (clk),
        .rst       (rst),
        .src_if    (alu_if),
        .grant_i   (grant[WB_SRC_ALU]),
        .valid_o   (slot_valid[WB_SRC_ALU]),
        .addr_o    (slot_addr[WB_SRC_ALU]),
        .data_o    (slot_data[WB_SRC_ALU]),
        .starved_o (slot_starved[WB_SRC_ALU])
    );

    // Pick one occupied slot; starved slots pre-empt the fixed order when guarded.
    always_comb begin
`ifdef WB_ARB_STARVE_GUARD_EN
        if (|slot_starved) begin
            grant = wb_fixed_pick(slot_starved);
        end else begin
            grant = wb_fixed_pick(slot_valid);
        end
`else
        grant = wb_fixed_pick(slot_valid);
`endif
    end

    logic            wb_valid_q, wb_valid_d;
    logic [4:0]      wb_addr_q, wb_addr_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;

    // Select the granted slot; address/data hold when nothing is granted.
    always_comb begin
        wb_valid_d = |grant;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        for (int i = 0; i < NUM_WB_SRC; i++) begin
            if (grant[i]) begin
                wb_addr_d = slot_addr[i];
                wb_data_d = slot_data[i];
            end
        end
    end

    // Registered register-file write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
        end
    end

    assign o_wb_rd_wvalid = wb_valid_q;
    assign o_wb_rd_waddr  = wb_addr_q;
    assign o_wb_rd_wdata  = wb_data_q;
    assign o_busy         = |slot_valid;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed self-checking bench for wb_arbiter
module tb_wb_arbiter;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    wb_arbiter_if #(.XLEN(XLEN)) alu_s ();
    wb_arbiter_if #(.XLEN(XLEN)) load_s ();
    wb_arbiter_if #(.XLEN(XLEN)) jump_s ();

    logic            wb_wvalid;
    logic [4:0]      wb_waddr;
    logic [XLEN-1:0] wb_wdata;
    logic            busy;

    wb_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_alu_wvalid   (alu_s.wvalid),
        .o_alu_wready   (alu_s.wready),
        .i_alu_waddr    (alu_s.waddr),
        .i_alu_wdata    (alu_s.wdata),
        .i_load_wvalid  (load_s.wvalid),
        .o_load_wready  (load_s.wready),
        .i_load_waddr   (load_s.waddr),
        .i_load_wdata   (load_s.wdata),
        .i_jump_wvalid  (jump_s.wvalid),
        .o_jump_wready  (jump_s.wready),
        .i_jump_waddr   (jump_s.waddr),
        .i_jump_wdata   (jump_s.wdata),
        .o_wb_rd_wvalid (wb_wvalid),
        .o_wb_rd_waddr  (wb_waddr),
        .o_wb_rd_wdata  (wb_wdata),
        .o_busy         (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_alu(input logic v, input logic [4:0] a, input logic [31:0] d);
        alu_s.wvalid = v; alu_s.waddr = a; alu_s.wdata = d;
    endtask
    task automatic drive_load(input logic v, input logic [4:0] a, input logic [31:0] d);
        load_s.wvalid = v; load_s.waddr = a; load_s.wdata = d;
    endtask
    task automatic drive_jump(input logic v, input logic [4:0] a, input logic [31:0] d);
        jump_s.wvalid = v; jump_s.waddr = a; jump_s.wdata = d;
    endtask
    task automatic idle();
        drive_alu(1'b0, 5'd0, 32'd0);
        drive_load(1'b0, 5'd0, 32'd0);
        drive_jump(1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        logic        alu_seen;
        logic        gap;
        int          strobes;
        int          first_k;
        int          last_k;
        logic [4:0]  q_addr [$];
        logic [31:0] q_data [$];

        // Reset state
        idle();
        tick();
        tick();
        rst = 1'b0;
        chk("rst_wvalid", 64'(wb_wvalid), 64'd0);
        chk("rst_waddr", 64'(wb_waddr), 64'd0);
        chk("rst_wdata", 64'(wb_wdata), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_alu_rdy", 64'(alu_s.wready), 64'd1);
        chk("rst_load_rdy", 64'(load_s.wready), 64'd1);
        chk("rst_jump_rdy", 64'(jump_s.wready), 64'd1);

        // Single ALU write, 2-cycle latency
        drive_alu(1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        idle();
        chk("t1_busy_n1", 64'(busy), 64'd1);
        chk("t1_wvalid_n1", 64'(wb_wvalid), 64'd0);
        tick();
        chk("t1_wvalid_n2", 64'(wb_wvalid), 64'd1);
        chk("t1_waddr_n2", 64'(wb_waddr), 64'd5);
        chk("t1_wdata_n2", 64'(wb_wdata), 64'hDEADBEEF);
        chk("t1_busy_n2", 64'(busy), 64'd0);
        tick();
        chk("t1_wvalid_n3", 64'(wb_wvalid), 64'd0);
        chk("t1_waddr_hold", 64'(wb_waddr), 64'd5);
        chk("t1_wdata_hold", 64'(wb_wdata), 64'hDEADBEEF);

        // All three sources at once: load, jump, alu order
        drive_load(1'b1, 5'd1, 32'h11);
        drive_jump(1'b1, 5'd2, 32'h22);
        drive_alu(1'b1, 5'd3, 32'h33);
        tick();
        idle();
        chk("t2_busy_n1", 64'(busy), 64'd1);
        chk("t2_alu_rdy_n1", 64'(alu_s.wready), 64'd0);
        chk("t2_jump_rdy_n1", 64'(jump_s.wready), 64'd0);
        chk("t2_load_rdy_n1", 64'(load_s.wready), 64'd1);
        chk("t2_wvalid_n1", 64'(wb_wvalid), 64'd0);
        tick();
        chk("t2_wvalid_n2", 64'(wb_wvalid), 64'd1);
        chk("t2_waddr_n2", 64'(wb_waddr), 64'd1);
        chk("t2_wdata_n2", 64'(wb_wdata), 64'h11);
        chk("t2_alu_rdy_n2", 64'(alu_s.wready), 64'd0);
        tick();
        chk("t2_wvalid_n3", 64'(wb_wvalid), 64'd1);
        chk("t2_waddr_n3", 64'(wb_waddr), 64'd2);
        chk("t2_wdata_n3", 64'(wb_wdata), 64'h22);
        chk("t2_alu_rdy_n3", 64'(alu_s.wready), 64'd1);
        tick();
        chk("t2_wvalid_n4", 64'(wb_wvalid), 64'd1);
        chk("t2_waddr_n4", 64'(wb_waddr), 64'd3);
        chk("t2_wdata_n4", 64'(wb_wdata), 64'h33);
        chk("t2_busy_n4", 64'(busy), 64'd0);
        tick();
        chk("t2_wvalid_n5", 64'(wb_wvalid), 64'd0);

        // Load to x0 is absorbed
        drive_load(1'b1, 5'd0, 32'h1234);
        chk("t3_load_rdy", 64'(load_s.wready), 64'd1);
        tick();
        idle();
        chk("t3_busy_n1", 64'(busy), 64'd0);
        chk("t3_wvalid_n1", 64'(wb_wvalid), 64'd0);
        tick();
        chk("t3_wvalid_n2", 64'(wb_wvalid), 64'd0);
        chk("t3_waddr_n2", 64'(wb_waddr), 64'd3);

        // Load streams while the ALU holds one write
        drive_alu(1'b1, 5'd7, 32'h77);
        drive_load(1'b1, 5'd9, 32'h900);
        tick();
        drive_alu(1'b0, 5'd0, 32'd0);
        alu_seen = 1'b0;
        gap      = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive_load(1'b1, 5'd9, 32'h901 + 32'(i));
            tick();
            if (wb_wvalid && wb_waddr == 5'd7) alu_seen = 1'b1;
            if (!wb_wvalid) gap = 1'b1;
        end
`ifdef WB_ARB_STARVE_GUARD_EN
        chk("t4_alu_issued", 64'(alu_seen), 64'd1);
`else
        chk("t4_alu_starved", 64'(alu_seen), 64'd0);
        chk("t4_load_no_gap", 64'(gap), 64'd0);
`endif
        idle();
        repeat (4) tick();
        chk("t4_drained", 64'(busy), 64'd0);

        // Reset while every slot is full
        drive_load(1'b1, 5'd11, 32'hB1);
        drive_jump(1'b1, 5'd12, 32'hB2);
        drive_alu(1'b1, 5'd13, 32'hB3);
        tick();
        idle();
        chk("t5_busy_full", 64'(busy), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_alu_rdy", 64'(alu_s.wready), 64'd1);
        chk("t5_load_rdy", 64'(load_s.wready), 64'd1);
        chk("t5_jump_rdy", 64'(jump_s.wready), 64'd1);
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_wvalid", 64'(wb_wvalid), 64'd0);
        strobes = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (wb_wvalid) strobes++;
        end
        chk("t5_no_strobe", 64'(strobes), 64'd0);

        // ALU back-to-back, addrs 1..8
        strobes = 0;
        first_k = -1;
        last_k  = -1;
        for (int k = 0; k < 11; k++) begin
            if (k < 8) begin
                drive_alu(1'b1, 5'(k + 1), 32'hA0 + 32'(k));
                chk("t6_alu_rdy", 64'(alu_s.wready), 64'd1);
            end else begin
                drive_alu(1'b0, 5'd0, 32'd0);
            end
            tick();
            if (wb_wvalid) begin
                strobes++;
                if (first_k < 0) first_k = k;
                last_k = k;
                q_addr.push_back(wb_waddr);
                q_data.push_back(wb_wdata);
            end
        end
        chk("t6_strobes", 64'(strobes), 64'd8);
        chk("t6_first", 64'(first_k), 64'd1);
        chk("t6_contig", 64'(last_k - first_k + 1), 64'd8);
        for (int j = 0; j < q_addr.size(); j++) begin
            chk("t6_addr", 64'(q_addr[j]), 64'(j + 1));
            chk("t6_data", 64'(q_data[j]), 64'(32'hA0 + 32'(j)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
